// File: rtl/standalone_hps_pio_pkg.sv
// Shared register map and STATUS bit positions for the standalone HPS PIO.
package standalone_hps_pio_pkg;

    typedef enum logic [2:0] {
        PIO_DATA      = 3'd0,
        PIO_BLINK_EN  = 3'd1,
        PIO_PERIOD    = 3'd2,
        PIO_STATUS    = 3'd3,
        PIO_OUTSET    = 3'd4,
        PIO_OUTCLEAR  = 3'd5,
        PIO_OUTTOGGLE = 3'd6,
        PIO_RSVD      = 3'd7
    } pio_addr_e;

    localparam int unsigned PIO_STAT_PHASE = 0;

endpackage

// File: rtl/standalone_hps_pio_blink_timer.sv
// Blink half-period timer: free-running counter that toggles phase on wrap.
module standalone_hps_pio_blink_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // Next count/phase; restart wins over a coincident wrap, and >= recovers
    // immediately when period is lowered below the running count.
    always_comb begin
        cnt_d   = cnt_q + PERIOD_W'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q >= period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Counter and phase flops with async clear/preset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/standalone_hps_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-bit blink.
module standalone_hps_pio_blink
    import standalone_hps_pio_pkg::*;
#(
    parameter int unsigned          WIDTH          = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE    = '0,
    parameter int unsigned          PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = 24'd12_499_999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                wr_en;
    pio_addr_e           addr;
    logic [WIDTH-1:0]    wd;
    logic                restart;
    logic                phase;
    logic                unused_wd;

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [31:0]         rd;

    assign wr_en     = chipselect & ~write_n;
    assign addr      = pio_addr_e'(address);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Register-file next state and STATUS restart decode.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        restart    = 1'b0;
        if (wr_en) begin
            case (addr)
                PIO_DATA:      data_d     = wd;
                PIO_BLINK_EN:  blink_en_d = wd;
                PIO_PERIOD:    period_d   = writedata[PERIOD_W-1:0];
                PIO_STATUS:    restart    = writedata[0];
                PIO_OUTSET:    data_d     = data_q | wd;
                PIO_OUTCLEAR:  data_d     = data_q & ~wd;
                PIO_OUTTOGGLE: data_d     = data_q ^ wd;
                default:       ;
            endcase
        end
    end

    // Blinking bits are masked low while phase is 0.
    always_comb begin
        out_d = data_q & ~(blink_en_q & {WIDTH{~phase}});
    end

    // Register file and output register with async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= DEFAULT_PERIOD;
            out_q      <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            out_q      <= out_d;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as 0.
    always_comb begin
        rd = '0;
        case (addr)
            PIO_DATA:     rd[WIDTH-1:0]    = data_q;
            PIO_BLINK_EN: rd[WIDTH-1:0]    = blink_en_q;
            PIO_PERIOD:   rd[PERIOD_W-1:0] = period_q;
            PIO_STATUS:   rd[PIO_STAT_PHASE] = phase;
            default:      ;
        endcase
    end

    assign readdata = rd;
    assign out_port = out_q;

    standalone_hps_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );

endmodule

// File: tb/tb_standalone_hps_pio_blink.sv
// Directed scoreboard bench over three widths (4, 1, 32) sharing one bus.
module tb_standalone_hps_pio_blink;
    import standalone_hps_pio_pkg::*;

    localparam logic [31:0] RV0 = 32'h6;
    localparam logic [31:0] RV1 = 32'h1;
    localparam logic [31:0] RV2 = 32'hDEAD_BEEF;
    localparam logic [31:0] DP0 = 32'd12_499_999;
    localparam logic [31:0] DP1 = 32'h0000_0ABC;
    localparam logic [31:0] DP2 = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [31:0] rd4, rd1, rd32;
    logic [3:0]  out4;
    logic        out1;
    logic [31:0] out32;

    int tests = 0;
    int fails = 0;

    logic [31:0] md [3];

    typedef struct {
        string             tag;
        logic [2:0][31:0]  e;
    } exp_t;
    exp_t sbq [$];

    always #5 clk = ~clk;

    standalone_hps_pio_blink #(
        .WIDTH       (4),
        .RESET_VALUE (4'h6)
    ) u_w4 (
        .clk (clk), .reset_n (reset_n), .address (address),
        .chipselect (chipselect), .write_n (write_n), .writedata (writedata),
        .readdata (rd4), .out_port (out4)
    );

    standalone_hps_pio_blink #(
        .WIDTH          (1),
        .RESET_VALUE    (1'b1),
        .PERIOD_W       (24),
        .DEFAULT_PERIOD (24'h000ABC)
    ) u_w1 (
        .clk (clk), .reset_n (reset_n), .address (address),
        .chipselect (chipselect), .write_n (write_n), .writedata (writedata),
        .readdata (rd1), .out_port (out1)
    );

    standalone_hps_pio_blink #(
        .WIDTH          (32),
        .RESET_VALUE    (32'hDEAD_BEEF),
        .PERIOD_W       (32),
        .DEFAULT_PERIOD (32'h8000_0010)
    ) u_w32 (
        .clk (clk), .reset_n (reset_n), .address (address),
        .chipselect (chipselect), .write_n (write_n), .writedata (writedata),
        .readdata (rd32), .out_port (out32)
    );

    function automatic logic [31:0] mask(int k);
        case (k)
            0:       return 32'h0000_000F;
            1:       return 32'h0000_0001;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] outv(int k);
        case (k)
            0:       return {28'b0, out4};
            1:       return {31'b0, out1};
            default: return out32;
        endcase
    endfunction

    function automatic logic [31:0] rdv(int k);
        case (k)
            0:       return rd4;
            1:       return rd1;
            default: return rd32;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, let the next posedge sample, release at negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            case (a)
                3'd0: md[k] = d & mask(k);
                3'd4: md[k] = md[k] | (d & mask(k));
                3'd5: md[k] = md[k] & ~(d & mask(k));
                3'd6: md[k] = md[k] ^ (d & mask(k));
                default: ;
            endcase
        end
    endtask

    task automatic rd_check(string tag, input logic [2:0] a,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2);
        logic [2:0][31:0] e;
        e = {e2, e1, e0};
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("%s[i%0d]", tag, k), rdv(k), e[k]);
        chipselect = 1'b0;
    endtask

    task automatic sb_push(string tag);
        exp_t x;
        x.tag = tag;
        for (int k = 0; k < 3; k++) x.e[k] = md[k];
        sbq.push_back(x);
    endtask

    task automatic sb_push_v(string tag, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2);
        exp_t x;
        x.tag = tag;
        x.e   = {e2, e1, e0};
        sbq.push_back(x);
    endtask

    task automatic sb_pop();
        exp_t x;
        @(negedge clk);
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty: observed 0 entries expected >=1");
        end else begin
            x = sbq.pop_front();
            for (int k = 0; k < 3; k++)
                check($sformatf("%s[i%0d]", x.tag, k), outv(k), x.e[k]);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        md[0] = RV0; md[1] = RV1; md[2] = RV2;

        // 1: reset values
        @(posedge clk);
        #1;
        check("rst_out[i0]", outv(0), RV0);
        check("rst_out[i1]", outv(1), RV1);
        check("rst_out[i2]", outv(2), RV2);
        rd_check("rst_data",  PIO_DATA,     RV0, RV1, RV2);
        rd_check("rst_blink", PIO_BLINK_EN, 32'h0, 32'h0, 32'h0);
        rd_check("rst_per",   PIO_PERIOD,   DP0, DP1, DP2);
        rd_check("rst_stat",  PIO_STATUS,   32'h1, 32'h1, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: DATA write with junk upper bits, 1-cycle output latency
        wr(PIO_DATA, 32'hA5A5_A5AA);
        check("lat_out[i0]", outv(0), RV0);
        check("lat_out[i1]", outv(1), RV1);
        check("lat_out[i2]", outv(2), RV2);
        sb_push("data_wr");
        sb_pop();
        rd_check("rd_data", PIO_DATA, 32'hA, 32'h0, 32'hA5A5_A5AA);

        // 2: atomic operations
        wr(PIO_DATA, 32'h5);            sb_push("data5");   sb_pop();
        wr(PIO_OUTSET, 32'h8);          sb_push("outset");  sb_pop();
        rd_check("rd_set", PIO_DATA, 32'hD, 32'h1, 32'hD);
        wr(PIO_OUTCLEAR, 32'h1);        sb_push("outclr");  sb_pop();
        rd_check("rd_clr", PIO_DATA, 32'hC, 32'h0, 32'hC);
        wr(PIO_OUTTOGGLE, 32'hF);       sb_push("outtgl");  sb_pop();
        rd_check("rd_tgl", PIO_DATA, 32'h3, 32'h1, 32'h3);
        wr(PIO_OUTSET, 32'hF000_0000);  sb_push("outset_hi"); sb_pop();
        wr(PIO_OUTCLEAR, 32'hF000_0000); sb_push("outclr_hi"); sb_pop();
        wr(PIO_RSVD, 32'hFFFF_FFFF);
        rd_check("rd_rsvd_wr", PIO_DATA, 32'h3, 32'h1, 32'h3);
        for (int a = 4; a < 8; a++)
            rd_check($sformatf("rd_wo%0d", a), 3'(a), 32'h0, 32'h0, 32'h0);
        wr(PIO_BLINK_EN, 32'hFFFF_FFFF);
        rd_check("rd_blink", PIO_BLINK_EN, 32'hF, 32'h1, 32'hFFFF_FFFF);
        wr(PIO_BLINK_EN, 32'h0);
        wr(PIO_PERIOD, 32'hFFFF_FF03);
        rd_check("rd_per_hi", PIO_PERIOD, 32'hFF_FF03, 32'hFF_FF03, 32'hFFFF_FF03);
        wr(PIO_PERIOD, 32'h3);

        // 3: blink PERIOD=3 after restart
        wr(PIO_DATA, 32'hF);            sb_push("dataF");   sb_pop();
        wr(PIO_BLINK_EN, 32'h1);
        wr(PIO_STATUS, 32'h1);
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2) == 0)
                sb_push_v($sformatf("blink%0d", i), 32'hF, 32'h1, 32'hF);
            else
                sb_push_v($sformatf("blink%0d", i), 32'hE, 32'h0, 32'hE);
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ph;
            ph = ((((i + 1) / 4) % 2) == 0) ? 32'h1 : 32'h0;
            sb_pop();
            rd_check($sformatf("blink_ph%0d", i), PIO_STATUS, ph, ph, ph);
        end

        // 4: period shrink below running count
        wr(PIO_PERIOD, 32'd100);
        wr(PIO_STATUS, 32'h1);
        repeat (50) @(negedge clk);
        rd_check("shrink_mid", PIO_STATUS, 32'h1, 32'h1, 32'h1);
        wr(PIO_PERIOD, 32'd10);
        rd_check("shrink_pre", PIO_STATUS, 32'h1, 32'h1, 32'h1);
        for (int j = 0; j < 25; j++) begin
            logic [31:0] ph;
            ph = (((j / 11) % 2) == 1) ? 32'h1 : 32'h0;
            @(negedge clk);
            rd_check($sformatf("shrink%0d", j), PIO_STATUS, ph, ph, ph);
        end

        // 5: restart coincident with wrap
        wr(PIO_PERIOD, 32'd2);
        wr(PIO_STATUS, 32'h1);
        repeat (2) @(negedge clk);
        wr(PIO_STATUS, 32'h1);
        for (int j = 0; j < 9; j++) begin
            logic [31:0] ph;
            ph = (((j / 3) % 2) == 0) ? 32'h1 : 32'h0;
            if (j > 0) @(negedge clk);
            rd_check($sformatf("rwrap%0d", j), PIO_STATUS, ph, ph, ph);
        end

        // 6: async reset mid-blink, between clock edges
        wr(PIO_PERIOD, 32'd3);
        wr(PIO_STATUS, 32'h1);
        repeat (5) @(negedge clk);
        #1;
        check("pre_rst[i0]", outv(0), 32'hE);
        check("pre_rst[i1]", outv(1), 32'h0);
        check("pre_rst[i2]", outv(2), 32'hE);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_out[i0]", outv(0), RV0);
        check("arst_out[i1]", outv(1), RV1);
        check("arst_out[i2]", outv(2), RV2);
        rd_check("arst_data",  PIO_DATA,     RV0, RV1, RV2);
        rd_check("arst_blink", PIO_BLINK_EN, 32'h0, 32'h0, 32'h0);
        rd_check("arst_per",   PIO_PERIOD,   DP0, DP1, DP2);
        rd_check("arst_stat",  PIO_STATUS,   32'h1, 32'h1, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
